// File: rtl/if_id_queue_if.sv
// IF->ID buffer handshake bundle: fetch-side push, decode-side pop,
// flush and occupancy. master = fetch/decode side, slave = buffer.
interface if_id_queue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_pc_4;
  logic [31:0]     in_instr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_4;
  logic [31:0]     out_instr;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [6:0]      out_opcode;
  logic [CW-1:0]   count;

  modport master (
    output in_valid, in_pc, in_pc_4, in_instr,
    output flush, out_ready,
    input  in_ready, out_valid, out_pc, out_pc_4,
    input  out_instr, out_rs1, out_rs2, out_opcode,
    input  count
  );

  modport slave (
    input  in_valid, in_pc, in_pc_4, in_instr,
    input  flush, out_ready,
    output in_ready, out_valid, out_pc, out_pc_4,
    output out_instr, out_rs1, out_rs2, out_opcode,
    output count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF->ID in-order FIFO of {pc, pc+4, instr} with flush and
// head pre-decode; presents a NOP whenever empty.
module if_id_queue #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic           clock,
  input logic           reset_n,
  if_id_queue_if.slave  q
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_4;
    logic [31:0]     instr;
  } if_id_t;

  if_id_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          vld;
  logic          push;
  logic          pop;
  if_id_t        head;
  logic [31:0]   instr;

  assign vld  = (cnt != '0);
  assign push = q.in_valid & q.in_ready;
  assign pop  = vld & q.out_ready;
  assign head = mem[rd_ptr];

  // in_ready looks only at occupancy, never at out_ready
  assign q.in_ready  = (cnt != FULL);
  assign q.out_valid = vld;
  assign q.count     = cnt;

  assign instr        = vld ? head.instr : NOP_INSTR;
  assign q.out_instr  = instr;
  assign q.out_pc     = vld ? head.pc : '0;
  assign q.out_pc_4   = vld ? head.pc_4 : '0;
  assign q.out_rs1    = instr[19:15];
  assign q.out_rs2    = instr[24:20];
  assign q.out_opcode = instr[6:0];

  always_ff @(posedge clock) begin
    if (push && !q.flush) begin
      mem[wr_ptr] <= '{
        pc:    q.in_pc,
        pc_4:  q.in_pc_4,
        instr: q.in_instr
      };
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        push && !pop: cnt <= cnt + CW'(1);
        pop && !push: cnt <= cnt - CW'(1);
        default:      cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: DEPTH=2 and DEPTH=4 instances share stimulus,
// each compared every cycle against a queue-based reference model.
module tb_if_id_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ent_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  if_id_queue_if #(.XLEN(32), .DEPTH(2)) b2 ();
  if_id_queue_if #(.XLEN(32), .DEPTH(4)) b4 ();

  if_id_queue #(.XLEN(32), .DEPTH(2)) u_d2 (
    .clock   (clock),
    .reset_n (reset_n),
    .q       (b2)
  );

  if_id_queue #(.XLEN(32), .DEPTH(4)) u_d4 (
    .clock   (clock),
    .reset_n (reset_n),
    .q       (b4)
  );

  ent_t m2[$];
  ent_t m4[$];
  int   checks = 0;
  int   errors = 0;
  int   pops4  = 0;
  logic acc4;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_dut(
    string n, int sz, ent_t hd, int depth,
    logic ov, logic ir,
    logic [31:0] opc, logic [31:0] opc4,
    logic [31:0] oin, logic [4:0] rs1,
    logic [4:0] rs2, logic [6:0] op,
    logic [4:0] cnt
  );
    ent_t e;
    logic [31:0] ins;
    e = (sz == 0) ? '{pc: 32'h0, pc4: 32'h0, instr: NOP} : hd;
    ins = e.instr;
    check({n, ".valid"}, ov, sz != 0);
    check({n, ".ready"}, ir, sz < depth);
    check({n, ".count"}, cnt, sz);
    check({n, ".pc"}, opc, e.pc);
    check({n, ".pc4"}, opc4, e.pc4);
    check({n, ".instr"}, oin, ins);
    check({n, ".rs1"}, rs1, ins[19:15]);
    check({n, ".rs2"}, rs2, ins[24:20]);
    check({n, ".op"}, op, ins[6:0]);
  endtask

  task automatic check_all(string tag);
    ent_t h2;
    ent_t h4;
    h2 = (m2.size() > 0) ? m2[0] : '0;
    h4 = (m4.size() > 0) ? m4[0] : '0;
    check_dut({tag, ".d2"}, m2.size(), h2, 2,
      b2.out_valid, b2.in_ready, b2.out_pc, b2.out_pc_4,
      b2.out_instr, b2.out_rs1, b2.out_rs2, b2.out_opcode,
      5'(b2.count));
    check_dut({tag, ".d4"}, m4.size(), h4, 4,
      b4.out_valid, b4.in_ready, b4.out_pc, b4.out_pc_4,
      b4.out_instr, b4.out_rs1, b4.out_rs2, b4.out_opcode,
      5'(b4.count));
  endtask

  task automatic drive(logic v, logic r, logic f,
                       logic [31:0] pc, logic [31:0] ins);
    b2.in_valid  = v;
    b4.in_valid  = v;
    b2.out_ready = r;
    b4.out_ready = r;
    b2.flush     = f;
    b4.flush     = f;
    b2.in_pc     = pc;
    b4.in_pc     = pc;
    b2.in_pc_4   = pc + 32'd4;
    b4.in_pc_4   = pc + 32'd4;
    b2.in_instr  = ins;
    b4.in_instr  = ins;
  endtask

  // One cycle: drive, check pre-edge outputs, then advance model.
  task automatic step(string tag, logic v, logic r, logic f,
                      logic [31:0] pc, logic [31:0] ins);
    ent_t e;
    logic p2, q2, p4, q4;
    @(negedge clock);
    drive(v, r, f, pc, ins);
    #1;
    check_all(tag);
    e  = '{pc: pc, pc4: pc + 32'd4, instr: ins};
    p2 = v && (m2.size() < 2);
    q2 = r && (m2.size() > 0);
    p4 = v && (m4.size() < 4);
    q4 = r && (m4.size() > 0);
    acc4 = p4 && !f;
    @(posedge clock);
    if (f) begin
      m2.delete();
      m4.delete();
    end else begin
      if (q2) void'(m2.pop_front());
      if (p2) m2.push_back(e);
      if (q4) begin
        void'(m4.pop_front());
        pops4++;
      end
      if (p4) m4.push_back(e);
    end
  endtask

  initial begin
    int k;
    int cyc;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #3;
    check_all("rst0");
    @(negedge clock);
    reset_n = 1'b1;

    // fill
    step("t2f", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step("t2a", 1'b1, 1'b0, 1'b0, 32'h100, 32'h00108093);
    step("t2b", 1'b1, 1'b0, 1'b0, 32'h104, 32'h00210113);
    step("t2c", 1'b1, 1'b0, 1'b0, 32'h108, 32'h00318193);
    step("t2d", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t2.pc_hold", b2.out_pc, 32'h100);
    check("t2.full", b2.in_ready, 1'b0);

    // stream
    step("t3f", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++)
      step("t3", 1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * i),
           32'h00000033 | (32'(i) << 15));
    step("t3d", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

    // full + pop
    step("t4f", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step("t4a", 1'b1, 1'b0, 1'b0, 32'h300, 32'h00500513);
    step("t4b", 1'b1, 1'b0, 1'b0, 32'h304, 32'h00600593);
    step("t4c", 1'b1, 1'b1, 1'b0, 32'h308, 32'h00700613);
    step("t4d", 1'b1, 1'b0, 1'b0, 32'h30C, 32'h00800693);
    step("t4e", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // flush with concurrent push
    step("t5a", 1'b1, 1'b0, 1'b1, 32'h500, 32'h00900713);
    step("t5b", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t5.instr", b2.out_instr, NOP);

    // async reset mid-stream with entries held
    step("t1a", 1'b1, 1'b0, 1'b0, 32'h600, 32'h00a00793);
    step("t1b", 1'b1, 1'b0, 1'b0, 32'h604, 32'h00b00813);
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("t1.pre_cnt", b2.count, 2);
    #1;
    reset_n = 1'b0;
    m2.delete();
    m4.delete();
    #1;
    check_all("t1");
    @(negedge clock);
    reset_n = 1'b1;

    // wrap: 20 in-order pushes with random out_ready
    step("t6f", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    pops4 = 0;
    k = 0;
    cyc = 0;
    while (k < 20 && cyc < 400) begin
      step("t6", 1'b1, 1'($urandom % 2), 1'b0,
           32'h700 + 32'(4 * k),
           32'h00A00093 + (32'(k) << 20));
      if (acc4) k++;
      cyc++;
    end
    check("t6.pushes", k, 20);
    cyc = 0;
    while (m4.size() > 0 && cyc < 50) begin
      step("t6d", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      cyc++;
    end
    check("t6.pops", pops4, 20);

    // random soak
    for (int i = 0; i < 300; i++)
      step("rnd", 1'($urandom % 4 != 0), 1'($urandom % 3 != 0),
           1'($urandom % 23 == 0), $urandom, $urandom);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
